// File: rtl/multi_chan_scoreboard.sv
// Multi-channel expected-data scoreboard: per-channel circular FIFOs of expected words,
// popped and compared against actual data. Optional macro SB_FATAL_EN halts simulation on any error event.
module multi_chan_scoreboard #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ADDR     = 3,
  parameter int unsigned DEPTH    = 2**ADDR,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CH_W     = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         exp_push,
  input  logic [CH_W-1:0]              exp_ch,
  input  logic [WIDTH-1:0]             exp_data,
  input  logic                         act_valid,
  input  logic [CH_W-1:0]              act_ch,
  input  logic [WIDTH-1:0]             act_data,
  output logic [CHANNELS*(ADDR+1)-1:0] level,
  output logic [CHANNELS-1:0]          empty,
  output logic [CHANNELS-1:0]          full,
  output logic                         mismatch,
  output logic [CNT_W-1:0]             match_cnt,
  output logic [CNT_W-1:0]             mismatch_cnt,
  output logic                         err_overflow,
  output logic                         err_underflow,
  output logic                         err_badch,
  output logic                         drained
);

  localparam int unsigned LW = ADDR + 1;

  logic [WIDTH-1:0] mem    [CHANNELS][DEPTH];
  logic [ADDR-1:0]  wr_ptr [CHANNELS];
  logic [ADDR-1:0]  rd_ptr [CHANNELS];
  logic [LW-1:0]    cnt    [CHANNELS];

  logic                exp_ok, act_ok;
  logic [CHANNELS-1:0] sel_push, sel_pop, push_c, pop_c;
  logic [WIDTH-1:0]    head;
  logic                cmp_c, miss_c, ovf_c, unf_c, bad_c;

  // Occupancy decodes
  for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_lvl
    assign level[gc*LW +: LW] = cnt[gc];
    assign empty[gc]          = (cnt[gc] == '0);
    assign full[gc]           = (cnt[gc] == LW'(DEPTH));
  end
  assign drained = &empty;

  // Channel decode, accept logic and head selection
  always_comb begin
    exp_ok   = 32'(exp_ch) < CHANNELS;
    act_ok   = 32'(act_ch) < CHANNELS;
    sel_push = '0;
    sel_pop  = '0;
    push_c   = '0;
    pop_c    = '0;
    head     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sel_push[c] = exp_push && exp_ok && (exp_ch == CH_W'(c));
      sel_pop[c]  = act_valid && act_ok && (act_ch == CH_W'(c));
      pop_c[c]    = sel_pop[c] && !empty[c];
      // a full channel still accepts a push when the same edge pops it
      push_c[c]   = sel_push[c] && (!full[c] || pop_c[c]);
      if (sel_pop[c]) head = mem[c][rd_ptr[c]];
    end
    cmp_c  = |pop_c;
    miss_c = cmp_c && (act_data != head);
    ovf_c  = |(sel_push & full & ~pop_c);
    unf_c  = |(sel_pop & empty);
    bad_c  = (exp_push && !exp_ok) || (act_valid && !act_ok);
  end

  // Queue storage, intentionally not reset
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (push_c[c]) mem[c][wr_ptr[c]] <= exp_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
      mismatch      <= 1'b0;
      match_cnt     <= '0;
      mismatch_cnt  <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_badch     <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (push_c[c])
          wr_ptr[c] <= (wr_ptr[c] == ADDR'(DEPTH-1)) ? '0 : wr_ptr[c] + ADDR'(1);
        if (pop_c[c])
          rd_ptr[c] <= (rd_ptr[c] == ADDR'(DEPTH-1)) ? '0 : rd_ptr[c] + ADDR'(1);
        if (push_c[c] && !pop_c[c])      cnt[c] <= cnt[c] + LW'(1);
        else if (pop_c[c] && !push_c[c]) cnt[c] <= cnt[c] - LW'(1);
      end
      mismatch <= miss_c;
      if (cmp_c && !miss_c && (match_cnt != '1))   match_cnt    <= match_cnt + CNT_W'(1);
      if (miss_c && (mismatch_cnt != '1))          mismatch_cnt <= mismatch_cnt + CNT_W'(1);
      if (ovf_c) err_overflow  <= 1'b1;
      if (unf_c) err_underflow <= 1'b1;
      if (bad_c) err_badch     <= 1'b1;
    end
  end

`ifdef SB_FATAL_EN
  // Halt on the first error event, naming the offending channel
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (miss_c) $fatal(1, "%0t %m: data mismatch on channel %0d", $time, act_ch);
      if (ovf_c)  $fatal(1, "%0t %m: overflow on channel %0d", $time, exp_ch);
      if (unf_c)  $fatal(1, "%0t %m: underflow on channel %0d", $time, act_ch);
      if (bad_c)  $fatal(1, "%0t %m: bad channel exp %0d act %0d", $time, exp_ch, act_ch);
    end
  end
`else
  // Error events only update the sticky flags and counters
`endif

endmodule

// File: tb/tb_multi_chan_scoreboard.sv
// Directed bench for multi_chan_scoreboard: stimulus queues expected compare results,
// a monitor pops and checks them after every act_valid edge.
module tb_multi_chan_scoreboard;

  localparam int unsigned CHANNELS = 4;
  localparam int unsigned ADDR     = 3;
  localparam int unsigned WIDTH    = 32;
  localparam int unsigned CH_W     = 3;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned LW       = ADDR + 1;

  logic                     clk, rstn;
  logic                     exp_push, act_valid;
  logic [CH_W-1:0]          exp_ch, act_ch;
  logic [WIDTH-1:0]         exp_data, act_data;
  logic [CHANNELS*LW-1:0]   level;
  logic [CHANNELS-1:0]      empty, full;
  logic                     mismatch, err_overflow, err_underflow, err_badch, drained;
  logic [CNT_W-1:0]         match_cnt, mismatch_cnt;

  typedef struct packed {
    logic             mis;
    logic [CNT_W-1:0] mc;
    logic [CNT_W-1:0] mmc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic act_seen = 1'b0;

  multi_chan_scoreboard #(
    .CHANNELS(CHANNELS), .ADDR(ADDR), .WIDTH(WIDTH), .CH_W(CH_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn),
    .exp_push(exp_push), .exp_ch(exp_ch), .exp_data(exp_data),
    .act_valid(act_valid), .act_ch(act_ch), .act_data(act_data),
    .level(level), .empty(empty), .full(full), .mismatch(mismatch),
    .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .err_badch(err_badch), .drained(drained)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [LW-1:0] lvl(input int c);
    return level[c*LW +: LW];
  endfunction

  // Monitor: an act_valid accepted outside reset yields one scoreboard entry
  always @(posedge clk) act_seen <= act_valid && rstn;

  always @(negedge clk) begin
    if (act_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor: compare observed with empty expectation queue");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_mismatch", 64'(mismatch), 64'(e.mis));
        chk("mon_match_cnt", 64'(match_cnt), 64'(e.mc));
        chk("mon_mismatch_cnt", 64'(mismatch_cnt), 64'(e.mmc));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    exp_push  = 1'b0;
    act_valid = 1'b0;
  endtask

  task automatic push(input int ch, input logic [WIDTH-1:0] d);
    exp_push = 1'b1; exp_ch = CH_W'(ch); exp_data = d;
    cycle();
  endtask

  task automatic act(input int ch, input logic [WIDTH-1:0] d,
                     input logic mis, input int mc, input int mmc);
    act_valid = 1'b1; act_ch = CH_W'(ch); act_data = d;
    exp_q.push_back('{mis: mis, mc: CNT_W'(mc), mmc: CNT_W'(mmc)});
    cycle();
  endtask

  task automatic both(input int pch, input logic [WIDTH-1:0] pd,
                      input int ach, input logic [WIDTH-1:0] ad,
                      input logic mis, input int mc, input int mmc);
    exp_push = 1'b1; exp_ch = CH_W'(pch); exp_data = pd;
    act_q_push(ach, ad, mis, mc, mmc);
    cycle();
  endtask

  task automatic act_q_push(input int ch, input logic [WIDTH-1:0] d,
                            input logic mis, input int mc, input int mmc);
    act_valid = 1'b1; act_ch = CH_W'(ch); act_data = d;
    exp_q.push_back('{mis: mis, mc: CNT_W'(mc), mmc: CNT_W'(mmc)});
  endtask

  initial begin
    rstn = 1'b0; exp_push = 1'b0; act_valid = 1'b0;
    exp_ch = '0; act_ch = '0; exp_data = '0; act_data = '0;
    #12;
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_empty", 64'(empty), 64'(4'hF));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_drained", 64'(drained), 64'(1));
    chk("rst_counts", 64'({match_cnt, mismatch_cnt}), 64'(0));
    chk("rst_flags", 64'({mismatch, err_overflow, err_underflow, err_badch}), 64'(0));
    @(negedge clk) rstn = 1'b1;

    // Two in-order matches on ch1
    push(1, 32'hA1);
    push(1, 32'hA2);
    chk("ch1_level2", 64'(lvl(1)), 64'(2));
    act(1, 32'hA1, 1'b0, 1, 0);
    act(1, 32'hA2, 1'b0, 2, 0);
    chk("ch1_drained", 64'(drained), 64'(1));

    // Single mismatch on ch0, pulse lasts one cycle
    push(0, 32'h10);
    act(0, 32'h11, 1'b1, 2, 1);
    chk("mis_pulse_hi", 64'(mismatch), 64'(1));
    cycle();
    chk("mis_pulse_lo", 64'(mismatch), 64'(0));
    chk("ch0_level0", 64'(lvl(0)), 64'(0));

    // Fill ch2, overflow, then full-channel push+pop and drain across wrap
    for (int i = 0; i < 8; i++) push(2, 32'h200 + 32'(i));
    chk("ch2_full", 64'(full), 64'(4'b0100));
    push(2, 32'h2FF);
    chk("ovf_flag", 64'(err_overflow), 64'(1));
    chk("ovf_level", 64'(lvl(2)), 64'(8));
    both(2, 32'h208, 2, 32'h200, 1'b0, 3, 1);
    chk("ch2_level_kept", 64'(lvl(2)), 64'(8));
    for (int i = 1; i <= 8; i++) act(2, 32'h200 + 32'(i), 1'b0, 3 + i, 1);
    chk("ch2_drained", 64'(lvl(2)), 64'(0));

    // Underflow and bad channel
    act(3, 32'h33, 1'b0, 11, 1);
    chk("unf_flag", 64'(err_underflow), 64'(1));
    chk("badch_pre", 64'(err_badch), 64'(0));
    act(5, 32'h55, 1'b0, 11, 1);
    chk("badch_flag", 64'(err_badch), 64'(1));
    chk("badch_level", 64'(level), 64'(0));

    // Independent push/pop on different channels
    push(1, 32'h55);
    both(0, 32'h77, 1, 32'h55, 1'b0, 12, 1);
    chk("xch_level0", 64'(lvl(0)), 64'(1));
    chk("xch_level1", 64'(lvl(1)), 64'(0));

    // Asynchronous reset with 3 entries queued
    push(3, 32'h31);
    push(3, 32'h32);
    chk("pre_rst_levels", 64'(level), 64'({4'd2, 4'd0, 4'd0, 4'd1}));
    #2 rstn = 1'b0;
    #1;
    chk("arst_level", 64'(level), 64'(0));
    chk("arst_counts", 64'({match_cnt, mismatch_cnt}), 64'(0));
    chk("arst_flags", 64'({err_overflow, err_underflow, err_badch}), 64'(0));
    chk("arst_drained", 64'(drained), 64'(1));
    act_valid = 1'b1; act_ch = CH_W'(0); act_data = 32'h77;
    @(posedge clk); #1;
    act_valid = 1'b0;
    chk("rst_edge_nocmp", 64'({match_cnt, mismatch_cnt, 1'b0, err_underflow}), 64'(0));
    @(negedge clk) rstn = 1'b1;

    // Normal operation after reset
    push(0, 32'hDEAD);
    act(0, 32'hDEAD, 1'b0, 1, 0);
    chk("post_rst_drained", 64'(drained), 64'(1));

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d expectations left, 0 required", exp_q.size());
    end
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_chan_scoreboard.md
MULTI_CHAN_SCOREBOARD -- requirements
Module: multi_chan_scoreboard

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent expected-data queues.
REQ-002 Parameter ADDR, default 3, log2 of per-channel queue depth.
REQ-003 Parameter DEPTH, default 2**ADDR, entries per channel.
REQ-004 Parameter WIDTH, default 32, data width.
REQ-005 Parameter CH_W, default 2, channel-select width; CHANNELS <= 2**CH_W is required.
REQ-006 Parameter CNT_W, default 16, match/mismatch counter width.
REQ-007 Ports (clock and reset first):
 - clk  in  1  clock.
 - rstn  in  1  reset, asynchronous, active-low.
 - exp_push  in  1  expected-data push strobe.
 - exp_ch  in  CH_W  channel for exp_push.
 - exp_data  in  WIDTH  expected data.
 - act_valid  in  1  actual-data strobe; pops and compares.
 - act_ch  in  CH_W  channel for act_valid.
 - act_data  in  WIDTH  actual data.
 - level  out  CHANNELS*(ADDR+1)  per-channel occupancy, channel c at bits [c*(ADDR+1) +: ADDR+1].
 - empty  out  CHANNELS  per-channel empty.
 - full  out  CHANNELS  per-channel full.
 - mismatch  out  1  one-cycle pulse, registered, one cycle after a failed compare.
 - match_cnt  out  CNT_W  total passing compares.
 - mismatch_cnt  out  CNT_W  total failing compares.
 - err_overflow, err_underflow, err_badch  out  1 each  sticky error flags.
 - drained  out  1  all channels empty.

Function
REQ-008 Each channel SHALL be an independent circular FIFO of DEPTH x WIDTH with wrapping read/write pointers.
REQ-009 exp_push with exp_ch < CHANNELS and the channel not full SHALL write exp_data at that channel's tail on the clk edge.
REQ-010 act_valid with act_ch < CHANNELS and the channel non-empty SHALL compare act_data to that channel's head as sampled before the edge and pop the head.
REQ-011 An equal compare SHALL increment match_cnt; an unequal compare SHALL increment mismatch_cnt and assert mismatch on the following cycle only.
REQ-012 Both counters SHALL saturate at all-ones.
REQ-013 act_valid on an empty channel SHALL set err_underflow, perform no pop, and change no counter; there is no push-to-compare bypass.
REQ-014 exp_push on a full channel SHALL set err_overflow and drop the data, unless the same edge carries act_valid to the same channel, in which case both the pop and the push are accepted and level is unchanged.
REQ-015 A push and a pop on different channels in the same cycle SHALL both be accepted independently.
REQ-016 A same-channel push and pop on a non-empty, non-full channel SHALL leave level unchanged.
REQ-017 exp_ch or act_ch >= CHANNELS with its strobe asserted SHALL set err_badch and leave all queues untouched.
REQ-018 empty, full and drained SHALL be combinational decodes of level: 0, DEPTH, and all-zero respectively.

Reset
REQ-019 rstn low SHALL asynchronously clear all pointers, level, counters, mismatch and error flags; empty and drained read 1, full reads 0.
REQ-020 Queue memory contents are not required to be cleared by reset.
REQ-021 Reset asserted mid-traffic SHALL discard all queued entries, and no compare SHALL occur on the edge at which rstn deasserts if rstn is still low at that edge.

Configuration
REQ-022 Macro SB_FATAL_EN: when defined, any mismatch, overflow, underflow or bad-channel event SHALL print the simulation time, instance path and channel, then halt the simulation.
REQ-023 Without SB_FATAL_EN, events SHALL only update the flags and counters, and simulation continues.

Verification
REQ-024 Push 0xA1, 0xA2 to ch1, then act 0xA1, 0xA2 on ch1 -> match_cnt=2, mismatch_cnt=0, drained=1.
REQ-025 Push 0x10 to ch0, act 0x11 on ch0 -> mismatch pulses one cycle, mismatch_cnt=1, level ch0=0.
REQ-026 Fill ch2 with 8 entries (DEPTH=8), push a 9th -> err_overflow=1, level ch2=8; next cycle push plus act on ch2 -> both accepted, level stays 8, FIFO order preserved across pointer wrap.
REQ-027 act_valid on empty ch3 -> err_underflow=1, counters unchanged; act_ch=5 with CHANNELS=4, CH_W=3 -> err_badch=1.
REQ-028 Same-cycle push to ch0 and act on ch1 (ch1 holding 0x55, act 0x55) -> level ch0=1, level ch1=0, match_cnt=1.
REQ-029 Assert rstn low with 3 entries queued -> all levels 0, counters and flags 0 immediately, without waiting for clk.
